// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver.
package ps2_pkg;

  // Prefix / special scan codes
  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_REL        = 8'hF0;
  localparam logic [7:0] PS2_PAUSE      = 8'hE1;
  // Bytes that follow E1 in the Pause make/break sequence and carry no key meaning
  localparam logic [2:0] PS2_PAUSE_TAIL = 3'd7;

  // Frame receiver states
  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  // Bit positions inside the ps2_key event bus
  localparam int PS2_KEY_TOGGLE   = 10;
  localparam int PS2_KEY_PRESSED  = 9;
  localparam int PS2_KEY_EXT      = 8;
  localparam int PS2_KEY_CODE_MSB = 7;

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes the raw PS/2 clock and data lines, debounces the clock and
// emits a one-cycle strobe on each accepted falling edge of the clock.
module ps2_line_filter #(
  parameter int FILTER = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clk_raw_i,
  input  logic dat_raw_i,
  output logic dat_o,
  output logic fall_o
);

  localparam int CW = $clog2(FILTER + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

  logic [1:0]    clk_sync_q;
  logic [1:0]    dat_sync_q;
  logic          clk_filt_q;
  logic [CW-1:0] cnt_q;
  logic          fall_q;

  // Two-stage synchronizers; both lines idle high
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], clk_raw_i};
      dat_sync_q <= {dat_sync_q[0], dat_raw_i};
    end
  end

  // Accept a new clock level only after FILTER consecutive differing samples
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_filt_q <= 1'b1;
      cnt_q      <= '0;
      fall_q     <= 1'b0;
    end else begin
      fall_q <= 1'b0;
      if (clk_sync_q[1] == clk_filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q      <= '0;
        clk_filt_q <= clk_sync_q[1];
        fall_q     <= clk_filt_q & ~clk_sync_q[1];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign dat_o  = dat_sync_q[1];
  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: assembles 11-bit device->host frames, validates
// parity/stop, folds E0/F0 prefixes and the Pause sequence into toggle-format
// key events on ps2_key.
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 48_000_000,
  parameter int FILTER     = 8,
  parameter int TIMEOUT_US = 1000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk_i,
  input  logic        ps2_dat_i,
  output logic [10:0] ps2_key,
  output logic        frame_err,
  output logic        busy
);

  localparam int TMO_LIMIT = (CLK_HZ / 1_000_000) * TIMEOUT_US;
  localparam int TMO_W     = (TMO_LIMIT > 1) ? $clog2(TMO_LIMIT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_LIMIT - 1);

  logic dat;
  logic fall;

  ps2_line_filter #(.FILTER(FILTER)) u_filter (
    .clk_i     (clk_sys),
    .rst_ni    (reset_n),
    .clk_raw_i (ps2_clk_i),
    .dat_raw_i (ps2_dat_i),
    .dat_o     (dat),
    .fall_o    (fall)
  );

  ps2_state_t       state_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       sh_q;
  logic             par_q;
  logic             par_ok_q;
  logic [TMO_W-1:0] tmo_q;
  logic             ext_q;
  logic             rel_q;
  logic [2:0]       skip_cnt_q;
  logic [10:0]      key_q;
  logic             frame_err_q;
  logic             busy_q;

  // Frame FSM, inter-edge timeout and byte/prefix handling; timeout wins over a coincident fall
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      sh_q        <= '0;
      par_q       <= 1'b0;
      par_ok_q    <= 1'b0;
      tmo_q       <= '0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      skip_cnt_q  <= '0;
      key_q       <= '0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (state_q != IDLE && tmo_q == TMO_LAST) begin
        state_q     <= IDLE;
        busy_q      <= 1'b0;
        tmo_q       <= '0;
        frame_err_q <= 1'b1;
        ext_q       <= 1'b0;
        rel_q       <= 1'b0;
      end else if (fall) begin
        tmo_q <= '0;
        case (state_q)
          IDLE: begin
            if (!dat) begin
              state_q   <= DATA;
              busy_q    <= 1'b1;
              bit_cnt_q <= '0;
              par_q     <= 1'b0;
            end
          end
          DATA: begin
            sh_q  <= {dat, sh_q[7:1]};
            par_q <= par_q ^ dat;
            if (bit_cnt_q == 3'd7) state_q <= PARITY;
            else bit_cnt_q <= bit_cnt_q + 3'd1;
          end
          PARITY: begin
            par_ok_q <= par_q ^ dat;
            state_q  <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (dat && par_ok_q) begin
              if (skip_cnt_q != 3'd0) begin
                skip_cnt_q <= skip_cnt_q - 3'd1;
              end else if (sh_q == PS2_PAUSE) begin
                skip_cnt_q <= PS2_PAUSE_TAIL;
              end else if (sh_q == PS2_EXT) begin
                ext_q <= 1'b1;
              end else if (sh_q == PS2_REL) begin
                rel_q <= 1'b1;
              end else begin
                key_q[PS2_KEY_TOGGLE]       <= ~key_q[PS2_KEY_TOGGLE];
                key_q[PS2_KEY_PRESSED]      <= ~rel_q;
                key_q[PS2_KEY_EXT]          <= ext_q;
                key_q[PS2_KEY_CODE_MSB:0]   <= sh_q;
                ext_q <= 1'b0;
                rel_q <= 1'b0;
              end
            end else begin
              frame_err_q <= 1'b1;
              ext_q       <= 1'b0;
              rel_q       <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end else if (state_q != IDLE) begin
        tmo_q <= tmo_q + 1'b1;
      end else begin
        tmo_q <= '0;
      end
    end
  end

  assign ps2_key   = key_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Scoreboard bench for ps2_key_rx: stimulus pushes expected events/errors,
// a negedge monitor pops and compares whenever the DUT reports something.
module tb_ps2_key_rx;

  // 1 MHz model clock: one cycle per microsecond keeps frames short
  localparam int CLK_HZ     = 1_000_000;
  localparam int FILTER     = 8;
  localparam int TIMEOUT_US = 1000;
  localparam int HALF       = 30;   // half of a 60 us bit period
  localparam int QTR        = 15;
  localparam int GAP        = 100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;
  logic        busy;

  ps2_key_rx #(
    .CLK_HZ     (CLK_HZ),
    .FILTER     (FILTER),
    .TIMEOUT_US (TIMEOUT_US)
  ) dut (
    .clk_sys   (clk),
    .reset_n   (reset_n),
    .ps2_clk_i (ps2_clk),
    .ps2_dat_i (ps2_dat),
    .ps2_key   (ps2_key),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit          is_err;
    logic [10:0] key;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   last_fall_cyc = 0;

  // reference model state: keyboard protocol semantics
  bit m_tog = 1'b0;
  bit m_ext = 1'b0;
  bit m_rel = 1'b0;
  int m_skip = 0;

  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %0h required %0h", name, act, expv);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_tog = 1'b0; m_ext = 1'b0; m_rel = 1'b0; m_skip = 0;
  endtask

  task automatic model_err();
    exp_t e;
    e.is_err = 1'b1; e.key = '0;
    exp_q.push_back(e);
    m_ext = 1'b0; m_rel = 1'b0;
  endtask

  // What a keyboard host should report for one accepted byte
  task automatic model_byte(input logic [7:0] b);
    exp_t e;
    if (m_skip > 0) m_skip--;
    else if (b == 8'hE1) m_skip = 7;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_rel = 1'b1;
    else begin
      m_tog = ~m_tog;
      e.is_err = 1'b0;
      e.key = {m_tog, ~m_rel, m_ext, b};
      exp_q.push_back(e);
      m_ext = 1'b0; m_rel = 1'b0;
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    p = ~^b;
    if (bad_par) p = ~p;
    return {~bad_stop, p, b, 1'b0};
  endfunction

  // Device-side waveform: data changes in the middle of each low phase
  task automatic drive_bits(input logic [10:0] bits, input int nfalls);
    ps2_dat = bits[0];
    wait_cyc(HALF);
    for (int i = 0; i < nfalls; i++) begin
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      wait_cyc(QTR);
      if (i < 10) ps2_dat = bits[i+1];
      else ps2_dat = 1'b1;
      wait_cyc(QTR);
      ps2_clk = 1'b1;
      wait_cyc(HALF);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    if (bad_par || bad_stop) model_err();
    else model_byte(b);
    drive_bits(frame_bits(b, bad_par, bad_stop), 11);
    ps2_dat = 1'b1;
    wait_cyc(GAP);
  endtask

  task automatic send_stall(input logic [7:0] b, input int nfalls);
    model_err();
    drive_bits(frame_bits(b, 1'b0, 1'b0), nfalls);
    check("busy_during_partial", 32'(busy), 32'd1);
    wait_cyc(2000);
    check("busy_after_timeout", 32'(busy), 32'd0);
    ps2_dat = 1'b1;
    wait_cyc(GAP);
  endtask

  // Monitor: every frame_err pulse or ps2_key change consumes one expectation
  logic [10:0] prev_key = '0;
  always @(negedge clk) begin
    exp_t e;
    int lat;
    if (!reset_n) begin
      prev_key = '0;
    end else begin
      if (frame_err && ps2_key != prev_key) begin
        checks++;
        $display("FAIL err_and_event_same_cycle: got both required only one");
      end
      if (frame_err) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_frame_err: got pulse required none");
        end else begin
          e = exp_q.pop_front();
          if (e.is_err) passes++;
          else $display("FAIL frame_err: got error pulse required event %03h", e.key);
        end
      end
      if (ps2_key != prev_key) begin
        checks++;
        lat = cyc - last_fall_cyc;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_event: got %03h required no event", ps2_key);
        end else begin
          e = exp_q.pop_front();
          if (e.is_err)
            $display("FAIL event: got key %03h required error pulse", ps2_key);
          else if (ps2_key !== e.key)
            $display("FAIL event_key: got %03h required %03h", ps2_key, e.key);
          else if (lat < FILTER + 1 || lat > FILTER + 6)
            $display("FAIL event_latency: got %0d cycles required %0d..%0d", lat, FILTER + 1, FILTER + 6);
          else
            passes++;
        end
        prev_key = ps2_key;
      end
    end
  end

  initial begin
    bit glitch_bad;
    logic [7:0] b;
    int r;

    // reset state
    wait_cyc(5);
    check("reset_key", 32'(ps2_key), 32'd0);
    check("reset_err", 32'(frame_err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    wait_cyc(20);

    // 1: plain make code
    send_frame(8'h1C, 0, 0);

    // 2: extended make then extended break
    send_frame(8'hE0, 0, 0);
    send_frame(8'h75, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);

    // 3: parity error then clean retry, plus stop-bit error
    send_frame(8'h29, 1, 0);
    send_frame(8'h29, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h33, 0, 1);
    send_frame(8'h33, 0, 0);

    // 4: break prefix, truncated frame, timeout, then clean key
    send_frame(8'hF0, 0, 0);
    send_stall(8'h55, 6);
    send_frame(8'h14, 0, 0);

    // 5: Pause sequence, then normal key
    send_frame(8'hE1, 0, 0);
    send_frame(8'h14, 0, 0);
    send_frame(8'h77, 0, 0);
    send_frame(8'hE1, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h14, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h77, 0, 0);
    send_frame(8'h05, 0, 0);

    // 6a: short clock glitch while idle is ignored
    glitch_bad = 1'b0;
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) glitch_bad = 1'b1;
    end
    check("glitch_busy", 32'(glitch_bad), 32'd0);

    // 6b: reset in the middle of a frame
    drive_bits(frame_bits(8'h44, 0, 0), 4);
    check("busy_mid_frame", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_key", 32'(ps2_key), 32'd0);
    check("async_reset_err", 32'(frame_err), 32'd0);
    check("async_reset_busy", 32'(busy), 32'd0);
    model_reset();
    ps2_dat = 1'b1;
    wait_cyc(5);
    reset_n = 1'b1;
    wait_cyc(50);
    send_frame(8'h44, 0, 0);

    // randomized traffic including prefixes, Pause and corrupted frames
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) b = 8'hE0;
      else if (r == 1) b = 8'hF0;
      else if (r == 2 && $urandom_range(0, 3) == 0) b = 8'hE1;
      else b = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      send_frame(b, r == 0, r == 1);
    end

    wait_cyc(50);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
